key_conditioner: RTL and testbench



---
 rtl/key_conditioner_pkg.sv | 17 +
 rtl/key_conditioner_if.sv | 16 +
 rtl/key_conditioner_debounce_cell.sv | 34 +++
 rtl/key_conditioner.sv | 53 +++++
 tb/tb_key_conditioner.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
// key_pkg: key codes, FSM states and default debounce length for key_conditioner
package key_pkg;
  localparam int DEBOUNCE_DEFAULT = 250000;
  localparam logic [2:0] KEY_I1 = 3'd0;
  localparam logic [2:0] KEY_I2 = 3'd1;
  localparam logic [2:0] KEY_I3 = 3'd2;
  localparam logic [2:0] KEY_I4 = 3'd3;
  localparam logic [2:0] KEY_ENTER = 3'd4;
  localparam logic [2:0] KEY_NONE = 3'd7;
  typedef enum logic {IDLE, HELD} state_t;
  // Lowest-index set bit wins, so I1 beats every other key
  function automatic logic [2:0] first_key(input logic [4:0] ev);
    first_key = KEY_NONE;
    for (int i = 4; i >= 0; i--)
      if (ev[i]) first_key = 3'(i);
  endfunction
endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw button levels in, conditioned press pulses and status out
interface key_conditioner_if;
  logic I1_raw, I2_raw, I3_raw, I4_raw, enter_raw;
  logic I1, I2, I3, I4, enter;
  logic [2:0] key_code;
  logic key_valid;
  logic busy;
  modport master (
    output I1_raw, I2_raw, I3_raw, I4_raw, enter_raw,
    input  I1, I2, I3, I4, enter, key_code, key_valid, busy
  );
  modport slave (
    input  I1_raw, I2_raw, I3_raw, I4_raw, enter_raw,
    output I1, I2, I3, I4, enter, key_code, key_valid, busy
  );
endinterface

// File: rtl/key_conditioner_debounce_cell.sv
// debounce_cell: 2-flop synchroniser plus counter debounce for one button
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_stable, r_rise;
  logic w_diff, w_flip;
  assign w_diff = r_sync[1] ^ r_stable;
  assign w_flip = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  // Any sample matching the stable level restarts the count; a full run of differing samples flips it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_stable <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw};
      r_cnt <= (!w_diff || w_flip) ? '0 : r_cnt + 1'b1;
      r_stable <= r_stable ^ w_flip;
      r_rise <= w_flip & ~r_stable;
    end
  end
  assign stable = r_stable;
  assign rise = r_rise;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounces five buttons and accepts one press at a time as a pulse plus code
module key_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input logic clk,
  input logic reset,
  key_conditioner_if.slave bus
);
  logic [4:0] w_raw, w_stable, w_rise, w_pulse, r_pulse;
  logic [2:0] w_code, r_code;
  logic w_hit, r_valid;
  state_t r_state, w_next;
  assign w_raw = {bus.enter_raw, bus.I4_raw, bus.I3_raw, bus.I2_raw, bus.I1_raw};
  for (genvar i = 0; i < 5; i++) begin : g_cell
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk(clk),
      .reset(reset),
      .raw(w_raw[i]),
      .stable(w_stable[i]),
      .rise(w_rise[i])
    );
  end
  // Accept a press only when idle; stay locked until every key has debounced back to released
  always_comb begin
    w_hit = (r_state == IDLE) && (|w_rise);
    w_code = w_hit ? first_key(w_rise) : r_code;
    w_pulse = w_hit ? (5'b1 << w_code) : 5'b0;
    w_next = w_hit ? HELD : ((r_state == HELD) && !(|w_stable)) ? IDLE : r_state;
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Registered outputs so nothing combinational reaches the ports
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulse <= '0;
      r_valid <= 1'b0;
      r_code <= KEY_NONE;
    end else begin
      r_pulse <= w_pulse;
      r_valid <= w_hit;
      r_code <= w_code;
    end
  end
  assign {bus.enter, bus.I4, bus.I3, bus.I2, bus.I1} = r_pulse;
  assign bus.key_valid = r_valid;
  assign bus.key_code = r_code;
  assign bus.busy = (r_state == HELD);
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios with a queued scoreboard checked by a pulse monitor
module tb_key_conditioner;
  import key_pkg::*;
  typedef struct {
    logic [2:0] code;
    int at;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t e;
  logic [4:0] pulses;
  key_conditioner_if kif ();
  key_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(kif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign pulses = {kif.enter, kif.I4, kif.I3, kif.I2, kif.I1};
  always @(negedge clk) begin
    if (pulses != 5'b0 || kif.key_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pulse cyc=%0d got pulses=%b code=%0d valid=%b required no pulse", cyc, pulses, kif.key_code, kif.key_valid);
      end else begin
        e = q.pop_front();
        if (pulses != (5'b1 << e.code) || !kif.key_valid || kif.key_code != e.code || cyc != e.at) begin
          bad++;
          $display("FAIL pulse got cyc=%0d pulses=%b code=%0d valid=%b required cyc=%0d pulses=%b code=%0d valid=1",
                   cyc, pulses, kif.key_code, kif.key_valid, e.at, 5'b1 << e.code, e.code);
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got %0d required %0d at cyc=%0d", name, act, req, cyc);
    end
  endtask
  task automatic set_raw(input int k, input logic v);
    case (k)
      0: kif.I1_raw = v;
      1: kif.I2_raw = v;
      2: kif.I3_raw = v;
      3: kif.I4_raw = v;
      default: kif.enter_raw = v;
    endcase
  endtask
  task automatic expect_press(input int k);
    q.push_back(exp_t'{3'(k), cyc + 7});
  endtask
  task automatic wait_idle();
    int n = 0;
    while (kif.busy && n < 100) begin
      tick(1);
      n++;
    end
    chk("idle", int'(kif.busy), 0);
  endtask
  initial begin
    int r;
    for (int k = 0; k < 5; k++) set_raw(k, 1'b0);
    tick(3);
    chk("rst_code", int'(kif.key_code), 7);
    chk("rst_busy", int'(kif.busy), 0);
    chk("rst_out", int'({pulses, kif.key_valid}), 0);
    reset = 1'b0;
    tick(2);
    set_raw(1, 1'b1);
    expect_press(1);
    tick(8);
    chk("clean_busy", int'(kif.busy), 1);
    tick(12);
    set_raw(1, 1'b0);
    r = cyc;
    tick(6);
    chk("busy_hold", int'(kif.busy), 1);
    tick(1);
    chk("busy_drop", int'(kif.busy), 0);
    chk("busy_cyc", cyc - r, 7);
    chk("code_held", int'(kif.key_code), 1);
    tick(3);
    repeat (3) begin
      set_raw(0, 1'b1);
      tick(2);
      set_raw(0, 1'b0);
      tick(2);
    end
    set_raw(0, 1'b1);
    expect_press(0);
    tick(15);
    set_raw(0, 1'b0);
    wait_idle();
    tick(3);
    set_raw(2, 1'b1);
    set_raw(4, 1'b1);
    expect_press(2);
    tick(15);
    set_raw(2, 1'b0);
    set_raw(4, 1'b0);
    wait_idle();
    tick(10);
    set_raw(0, 1'b1);
    expect_press(0);
    tick(10);
    set_raw(3, 1'b1);
    tick(10);
    set_raw(3, 1'b0);
    tick(10);
    set_raw(0, 1'b0);
    wait_idle();
    tick(2);
    set_raw(3, 1'b1);
    expect_press(3);
    tick(10);
    chk("lock_code", int'(kif.key_code), 3);
    set_raw(3, 1'b0);
    wait_idle();
    tick(3);
    set_raw(4, 1'b1);
    expect_press(4);
    tick(10);
    chk("pre_rst_busy", int'(kif.busy), 1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_code", int'(kif.key_code), 7);
    chk("mid_rst_busy", int'(kif.busy), 0);
    chk("mid_rst_out", int'({pulses, kif.key_valid}), 0);
    reset = 1'b0;
    expect_press(4);
    tick(12);
    set_raw(4, 1'b0);
    wait_idle();
    tick(3);
    for (int k = 0; k < 5; k++) begin
      set_raw(k, 1'b1);
      expect_press(k);
      tick(10);
      set_raw(k, 1'b0);
      tick(10);
    end
    wait_idle();
    tick(5);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
